// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA raster timing path.
//   phase_t      - per-axis raster phase (visible, front porch, sync, back porch)
//   COORD_W      - width of the horizontal/vertical coordinate counters
//   DEF_*        - default 800x600@72 timing (50 MHz pixel clock)
package vga_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_t;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BACK    = 64;
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BACK    = 23;

endpackage

// File: rtl/vga_if.sv
// vga_if: bundle between the timing generator, the game engine and the pins.
//   PIXEL        - colour {R,G,B} returned by the engine
//   PIXEL_H/V    - current raster coordinate
//   FRAME_START  - one-clock pulse while the counters sit at (0,0)
//   VGA_*        - sync and colour pins
// master: the timing generator; slave: the engine / pin consumer.
interface vga_if;
  import vga_pkg::*;

  logic [2:0]         PIXEL;
  logic [COORD_W-1:0] PIXEL_H;
  logic [COORD_W-1:0] PIXEL_V;
  logic               FRAME_START;
  logic               VGA_HSYNC;
  logic               VGA_VSYNC;
  logic               VGA_R;
  logic               VGA_G;
  logic               VGA_B;

  modport master (
    input  PIXEL,
    output PIXEL_H, PIXEL_V, FRAME_START,
    output VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output PIXEL,
    input  PIXEL_H, PIXEL_V, FRAME_START,
    input  VGA_HSYNC, VGA_VSYNC, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   i_clk    - pixel clock
//   i_rst    - asynchronous active-high reset
//   i_adv    - advance enable (every clock for h, h-wrap for v)
//   o_count  - coordinate, 0..TOTAL-1
//   o_phase  - registered phase, always consistent with o_count
//   o_wrap   - high on the advancing clock where the count returns to 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = 800,
  parameter int FRONT   = 56,
  parameter int SYNC    = 120,
  parameter int BACK    = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_adv,
  output logic [COORD_W-1:0] o_count,
  output phase_t             o_phase,
  output logic               o_wrap
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  // Each phase must be non-empty and the line/frame must fit the counter.
  if (TOTAL > (2 ** COORD_W) - 1 || VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
    $error("vga_axis_counter: illegal timing parameters");
  end

  // Last count of each phase; the phase register moves on the same clock
  // the counter steps past it, so phase and count never disagree.
  localparam logic [COORD_W-1:0] END_VIS   = COORD_W'(VISIBLE - 1);
  localparam logic [COORD_W-1:0] END_FRONT = COORD_W'(VISIBLE + FRONT - 1);
  localparam logic [COORD_W-1:0] END_SYNC  = COORD_W'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [COORD_W-1:0] END_TOTAL = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] r_count;
  phase_t             r_phase;
  logic               w_wrap;

  assign w_wrap = i_adv && (r_count == END_TOTAL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_phase <= PH_VISIBLE;
    end else if (i_adv) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
      case (r_phase)
        PH_VISIBLE: if (r_count == END_VIS)   r_phase <= PH_FRONT;
        PH_FRONT:   if (r_count == END_FRONT) r_phase <= PH_SYNC;
        PH_SYNC:    if (r_count == END_SYNC)  r_phase <= PH_BACK;
        PH_BACK:    if (r_count == END_TOTAL) r_phase <= PH_VISIBLE;
        default:    r_phase <= PH_VISIBLE;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_phase = r_phase;
  assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator and pixel output stage.
//   VGA_CLOCK - pixel clock (rising edge)
//   RESET     - asynchronous active-high reset
//   vga       - vga_if master: PIXEL in; PIXEL_H/V, FRAME_START, sync and
//               colour pins out
// Blanking and sync are delayed PIPE_DELAY clocks to match the engine's
// colour latency, then registered together with PIXEL so colour, blanking
// and sync reach the pins coherently, PIPE_DELAY+1 clocks after the
// coordinate that produced them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE  = DEF_H_VISIBLE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_VISIBLE  = DEF_V_VISIBLE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   PIPE_DELAY = 2
) (
  input logic   VGA_CLOCK,
  input logic   RESET,
  vga_if.master vga
);

  if (PIPE_DELAY < 1) begin : g_bad_delay
    $error("vga_timing: PIPE_DELAY must be at least 1");
  end

  logic [COORD_W-1:0] w_h_count;
  logic [COORD_W-1:0] w_v_count;
  phase_t             w_h_phase;
  phase_t             w_v_phase;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [2:0]         w_raw;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .i_clk(VGA_CLOCK), .i_rst(RESET), .i_adv(1'b1),
    .o_count(w_h_count), .o_phase(w_h_phase), .o_wrap(w_h_wrap)
  );

  // The vertical axis only steps on the last clock of a line.
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .i_clk(VGA_CLOCK), .i_rst(RESET), .i_adv(w_h_wrap),
    .o_count(w_v_count), .o_phase(w_v_phase), .o_wrap(w_v_wrap)
  );

  // Packed as {de, hs, vs}.
  assign w_raw = {(w_h_phase == PH_VISIBLE) && (w_v_phase == PH_VISIBLE),
                  w_h_phase == PH_SYNC,
                  w_v_phase == PH_SYNC};

  logic [2:0] r_pipe [PIPE_DELAY];
  logic [2:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_frame_start;

  always_ff @(posedge VGA_CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= 3'b000;
      r_rgb         <= 3'b000;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b1;
    end else begin
      r_pipe[0] <= w_raw;
      for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      r_rgb   <= r_pipe[PIPE_DELAY-1][2] ? vga.PIXEL : 3'b000;
      r_hsync <= ~(r_pipe[PIPE_DELAY-1][1] ^ SYNC_POL);
      r_vsync <= ~(r_pipe[PIPE_DELAY-1][0] ^ SYNC_POL);
      // Counters land on (0,0) exactly when both axes wrap together.
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

  assign vga.PIXEL_H     = w_h_count;
  assign vga.PIXEL_V     = w_v_count;
  assign vga.FRAME_START = r_frame_start;
  assign vga.VGA_HSYNC   = r_hsync;
  assign vga.VGA_VSYNC   = r_vsync;
  assign vga.VGA_R       = r_rgb[2];
  assign vga.VGA_G       = r_rgb[1];
  assign vga.VGA_B       = r_rgb[0];

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing.
// dut_d runs the default 800x600@72 timing (positive syncs); dut_s runs a
// tiny raster (H 8/2/3/2 = 15, V 4/1/2/1 = 8, negative syncs) so whole
// frames, wrap, alignment and mid-frame reset fit in a short run.
module tb_vga_timing;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  logic pix_mode = 1'b0;
  logic [2:0] pix_d1_s = 3'b000;
  logic [2:0] pix_d2_s = 3'b000;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_if vif_d ();
  vga_if vif_s ();

  vga_timing dut_d (
    .VGA_CLOCK(clk), .RESET(rst_d), .vga(vif_d.master)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) dut_s (
    .VGA_CLOCK(clk), .RESET(rst_s), .vga(vif_s.master)
  );

  // Two-clock engine model: colour = PIXEL_H mod 8, valid two clocks later.
  always @(posedge clk) begin
    pix_d1_s <= vif_s.PIXEL_H[2:0];
    pix_d2_s <= pix_d1_s;
  end

  assign vif_d.PIXEL = 3'b111;
  assign vif_s.PIXEL = pix_mode ? pix_d2_s : 3'b111;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Default-timing directed points: clocks after release, H, V, HSYNC, RGB.
  int tn   [15] = '{1, 2, 3, 802, 803, 858, 859, 978, 979, 1039, 1040, 1043, 1898, 1899, 2019};
  int th   [15] = '{1, 2, 3, 802, 803, 858, 859, 978, 979, 1039, 0,    3,    858,  859,  979};
  int tv   [15] = '{0, 0, 0, 0,   0,   0,   0,   0,   0,   0,    1,    1,    1,    1,    1};
  int ths  [15] = '{0, 0, 0, 0,   0,   0,   1,   1,   0,   0,    0,    0,    0,    1,    0};
  int trgb [15] = '{0, 0, 7, 7,   0,   0,   0,   0,   0,   0,    0,    7,    0,    0,    0};

  initial begin
    int idx;
    int rgb_cnt, hs_cnt, vs_cnt, fs_cnt;
    int k, h, v, exp_rgb;
    int waited;

    // ---- reset state, both instances, PIXEL held at 111 ----
    tick(); tick(); tick();
    chk("rst_d_h", 32'(vif_d.PIXEL_H), 0);
    chk("rst_d_v", 32'(vif_d.PIXEL_V), 0);
    chk("rst_d_fs", 32'(vif_d.FRAME_START), 1);
    chk("rst_d_hs", 32'(vif_d.VGA_HSYNC), 0);
    chk("rst_d_vs", 32'(vif_d.VGA_VSYNC), 0);
    chk("rst_d_rgb", 32'({vif_d.VGA_R, vif_d.VGA_G, vif_d.VGA_B}), 0);
    chk("rst_s_hs", 32'(vif_s.VGA_HSYNC), 1);
    chk("rst_s_vs", 32'(vif_s.VGA_VSYNC), 1);
    chk("rst_s_fs", 32'(vif_s.FRAME_START), 1);

    // ---- default timing: latency, line wrap, hsync edges ----
    rst_d = 1'b0;
    idx = 0;
    for (int n = 1; n <= 2019; n++) begin
      tick();
      if (idx < 15 && n == tn[idx]) begin
        $display("step d n=%0d H=%0d V=%0d HS=%0d RGB=%0d", n, vif_d.PIXEL_H, vif_d.PIXEL_V,
                 vif_d.VGA_HSYNC, {vif_d.VGA_R, vif_d.VGA_G, vif_d.VGA_B});
        chk($sformatf("d_h@%0d", n), 32'(vif_d.PIXEL_H), 32'(th[idx]));
        chk($sformatf("d_v@%0d", n), 32'(vif_d.PIXEL_V), 32'(tv[idx]));
        chk($sformatf("d_fs@%0d", n), 32'(vif_d.FRAME_START), 0);
        chk($sformatf("d_hs@%0d", n), 32'(vif_d.VGA_HSYNC), 32'(ths[idx]));
        chk($sformatf("d_vs@%0d", n), 32'(vif_d.VGA_VSYNC), 0);
        chk($sformatf("d_rgb@%0d", n), 32'({vif_d.VGA_R, vif_d.VGA_G, vif_d.VGA_B}), 32'(trgb[idx]));
        idx++;
      end
    end

    // ---- small raster: one full frame of pins with PIXEL=111 ----
    rst_s = 1'b0;
    rgb_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    for (int n = 1; n <= 122; n++) begin
      tick();
      if (n >= 3) begin
        if ({vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B} == 3'b111) rgb_cnt++;
        if (vif_s.VGA_HSYNC == 1'b0) hs_cnt++;
        if (vif_s.VGA_VSYNC == 1'b0) vs_cnt++;
      end
      if (n <= 120 && vif_s.FRAME_START) fs_cnt++;
      if (n == 2)   chk("s_rgb@2", 32'({vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}), 0);
      if (n == 3)   chk("s_rgb@3", 32'({vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}), 7);
      if (n == 77)  chk("s_vs@77", 32'(vif_s.VGA_VSYNC), 1);
      if (n == 78)  chk("s_vs@78", 32'(vif_s.VGA_VSYNC), 0);
      if (n == 119) begin
        chk("s_h@119", 32'(vif_s.PIXEL_H), 14);
        chk("s_v@119", 32'(vif_s.PIXEL_V), 7);
      end
      if (n == 120) begin
        chk("s_h@120", 32'(vif_s.PIXEL_H), 0);
        chk("s_v@120", 32'(vif_s.PIXEL_V), 0);
        chk("s_fs@120", 32'(vif_s.FRAME_START), 1);
      end
      if (n == 121) chk("s_fs@121", 32'(vif_s.FRAME_START), 0);
    end
    $display("frame s rgb_clocks=%0d hs_clocks=%0d vs_clocks=%0d fs_pulses=%0d",
             rgb_cnt, hs_cnt, vs_cnt, fs_cnt);
    chk("s_rgb_count", 32'(rgb_cnt), 32);
    chk("s_hs_count", 32'(hs_cnt), 24);
    chk("s_vs_count", 32'(vs_cnt), 30);
    chk("s_fs_count", 32'(fs_cnt), 1);

    // ---- alignment: engine returns h mod 8 two clocks later ----
    pix_mode = 1'b1;
    for (int n = 123; n <= 152; n++) begin
      tick();
      k = n - 3;
      h = k % 15;
      v = (k / 15) % 8;
      exp_rgb = (h < 8 && v < 4) ? (h % 8) : 0;
      $display("align n=%0d h=%0d v=%0d rgb=%0d", n, h, v, {vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B});
      chk($sformatf("s_align@%0d", n), 32'({vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}), 32'(exp_rgb));
    end
    pix_mode = 1'b0;

    // ---- mid-frame reset while the hsync pin is active ----
    waited = 0;
    while (!(vif_s.PIXEL_V == 11'd1 && vif_s.PIXEL_H == 11'd13) && waited < 200) begin
      tick();
      waited++;
    end
    chk("s_wait_bound", 32'(waited < 200), 1);
    chk("s_pre_rst_hs", 32'(vif_s.VGA_HSYNC), 0);
    rst_s = 1'b1;
    #1;
    $display("midreset H=%0d V=%0d HS=%0d", vif_s.PIXEL_H, vif_s.PIXEL_V, vif_s.VGA_HSYNC);
    chk("s_mr_h", 32'(vif_s.PIXEL_H), 0);
    chk("s_mr_v", 32'(vif_s.PIXEL_V), 0);
    chk("s_mr_fs", 32'(vif_s.FRAME_START), 1);
    chk("s_mr_hs", 32'(vif_s.VGA_HSYNC), 1);
    chk("s_mr_vs", 32'(vif_s.VGA_VSYNC), 1);
    chk("s_mr_rgb", 32'({vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}), 0);
    for (int n = 0; n < 5; n++) tick();
    chk("s_mr_hold_h", 32'(vif_s.PIXEL_H), 0);
    rst_s = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      $display("release n=%0d H=%0d HS=%0d VS=%0d RGB=%0d", n, vif_s.PIXEL_H, vif_s.VGA_HSYNC,
               vif_s.VGA_VSYNC, {vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B});
      chk($sformatf("s_rel_hs@%0d", n), 32'(vif_s.VGA_HSYNC), (n == 13 || n == 14) ? 0 : 1);
      chk($sformatf("s_rel_vs@%0d", n), 32'(vif_s.VGA_VSYNC), 1);
      chk($sformatf("s_rel_rgb@%0d", n), 32'({vif_s.VGA_R, vif_s.VGA_G, vif_s.VGA_B}),
          (n >= 3 && n <= 10) ? 7 : 0);
    end
    chk("s_rel_h@14", 32'(vif_s.PIXEL_H), 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
